// File: rtl/decode_stage_q.sv
// decode_stage_q: decode stage of the multicycle datapath.
// A small instruction queue sits in front of the instruction register. The
// opcode and the extended immediate are decoded combinationally from the IR.
// Prefix instructions carry extra immediate bits for the instruction that
// follows them. The block also holds the comp code register.
module decode_stage_q #(
    parameter int                    INSTR_W   = 16,
    parameter int                    OPCODE_W  = 4,
    parameter int                    IMM_W     = 16,
    parameter int                    CC_W      = 2,
    parameter int                    DEPTH     = 2,
    parameter logic [OPCODE_W-1:0]   PREFIX_OP = 4'hE
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       instr_in,
    input  logic                     irw,
    input  logic                     imm_sext,
    input  logic                     ccw,
    input  logic [CC_W-1:0]          cc_in,
    output logic [OPCODE_W-1:0]      opcodeOut,
    output logic [IMM_W-1:0]         immOut,
    output logic [CC_W-1:0]          compcodeOut,
    output logic                     ir_valid,
    output logic                     ir_prefixed,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int FW    = INSTR_W - OPCODE_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        PFX_IDLE,
        PFX_PENDING
    } pfx_state_t;

    // Queue storage and bookkeeping
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    // Head-of-queue views used when the IR is loaded
    logic [INSTR_W-1:0] head;
    logic [FW-1:0]      head_field;
    logic               head_is_pfx;

    // Prefix tracking
    pfx_state_t         state;
    pfx_state_t         state_next;
    logic               capture_pfx;
    logic               apply_pfx;
    logic [FW-1:0]      pfx_reg;
    logic [FW-1:0]      ir_pfx;

    // Instruction register and decode
    logic [INSTR_W-1:0] ir;
    logic [FW-1:0]      field;
    logic [2*FW-1:0]    joined;

    assign in_ready    = (count != CNT_W'(DEPTH));
    assign push        = in_valid && in_ready;
    assign pop         = irw && (count != '0);
    assign q_count     = count;

    assign head        = mem[rd_ptr];
    assign head_field  = head[INSTR_W-1:OPCODE_W];
    assign head_is_pfx = (head[OPCODE_W-1:0] == PREFIX_OP);

    // Queue pointers and occupancy; pointers wrap because DEPTH is a power of 2
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments on all state so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage write; entries are only read once counted valid
    always_ff @(posedge CLK) begin
        // NOTE: the storage array is deliberately not reset; occupancy is
        // tracked by count, so stale contents are never observed.
        if (push && !reset) mem[wr_ptr] <= instr_in;
    end

    // Prefix FSM: state register
    always_ff @(posedge CLK) begin
        if (reset) state <= PFX_IDLE;
        else       state <= state_next;
    end

    // Prefix FSM: next state, only a pop can move it
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unset,
        // which would otherwise infer a latch.
        state_next = state;
        if (pop) begin
            if (head_is_pfx) state_next = PFX_PENDING;
            else             state_next = PFX_IDLE;
        end
    end

    // Prefix FSM: strobes for capturing and consuming prefix bits
    always_comb begin
        capture_pfx = pop && head_is_pfx;
        apply_pfx   = pop && !head_is_pfx && (state == PFX_PENDING);
    end

    // Instruction register, its valid flag and the prefix data registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            ir          <= '0;
            ir_valid    <= 1'b0;
            ir_prefixed <= 1'b0;
            ir_pfx      <= '0;
            pfx_reg     <= '0;
        end else begin
            if (pop) begin
                ir          <= head;
                ir_valid    <= 1'b1;
                ir_prefixed <= apply_pfx;
            end
            if (apply_pfx)   ir_pfx  <= pfx_reg;
            if (capture_pfx) pfx_reg <= head_field;
        end
    end

    assign opcodeOut = ir[OPCODE_W-1:0];
    assign field     = ir[INSTR_W-1:OPCODE_W];
    assign joined    = {ir_pfx, field};

    // Immediate build: the prefixed form ignores imm_sext
    always_comb begin
        if (ir_prefixed)   immOut = IMM_W'(joined);
        else if (imm_sext) immOut = IMM_W'($signed(field));
        else               immOut = IMM_W'(field);
    end

    // Comp code register, independent of queue and IR activity
    always_ff @(posedge CLK) begin
        if (reset)    compcodeOut <= '0;
        else if (ccw) compcodeOut <= cc_in;
    end

endmodule

// File: tb/tb_decode_stage_q.sv
// Directed testbench for decode_stage_q with default parameters.
// Inputs are driven 1 ns after each rising edge; outputs are sampled there.
module tb_decode_stage_q;

    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr_in;
    logic        irw;
    logic        imm_sext;
    logic        ccw;
    logic [1:0]  cc_in;
    logic [3:0]  opcodeOut;
    logic [15:0] immOut;
    logic [1:0]  compcodeOut;
    logic        ir_valid;
    logic        ir_prefixed;
    logic [1:0]  q_count;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage_q dut (
        .CLK         (CLK),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr_in    (instr_in),
        .irw         (irw),
        .imm_sext    (imm_sext),
        .ccw         (ccw),
        .cc_in       (cc_in),
        .opcodeOut   (opcodeOut),
        .immOut      (immOut),
        .compcodeOut (compcodeOut),
        .ir_valid    (ir_valid),
        .ir_prefixed (ir_prefixed),
        .q_count     (q_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] instr;
        logic        sext;
        logic [3:0]  op;
        logic [15:0] imm;
        logic        pfx;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        in_valid = 1'b1;
        instr_in = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_word();
        irw = 1'b1;
        tick();
        irw = 1'b0;
    endtask

    initial begin
        // Plain, sign/zero extension, prefix, prefix overwrite, prefix with sext ignored
        vecs[0] = '{16'h02AF, 1'b0, 4'hF, 16'h002A, 1'b0};
        vecs[1] = '{16'hFFF3, 1'b1, 4'h3, 16'hFFFF, 1'b0};
        vecs[2] = '{16'hFFF3, 1'b0, 4'h3, 16'h0FFF, 1'b0};
        vecs[3] = '{16'h005E, 1'b0, 4'hE, 16'h0005, 1'b0};
        vecs[4] = '{16'h0121, 1'b0, 4'h1, 16'h5012, 1'b1};
        vecs[5] = '{16'h02AF, 1'b0, 4'hF, 16'h002A, 1'b0};
        vecs[6] = '{16'h800E, 1'b1, 4'hE, 16'hF800, 1'b0};
        vecs[7] = '{16'h7FFE, 1'b0, 4'hE, 16'h07FF, 1'b0};
        vecs[8] = '{16'hABC5, 1'b1, 4'h5, 16'hFABC, 1'b1};
        vecs[9] = '{16'h1234, 1'b1, 4'h4, 16'h0123, 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        instr_in = '0;
        irw      = 1'b0;
        imm_sext = 1'b0;
        ccw      = 1'b0;
        cc_in    = '0;
        tick();
        tick();

        check("rst q_count",     32'(q_count),     32'd0);
        check("rst in_ready",    32'(in_ready),    32'd1);
        check("rst ir_valid",    32'(ir_valid),    32'd0);
        check("rst opcode",      32'(opcodeOut),   32'd0);
        check("rst imm",         32'(immOut),      32'd0);
        check("rst compcode",    32'(compcodeOut), 32'd0);
        check("rst ir_prefixed", 32'(ir_prefixed), 32'd0);
        reset = 1'b0;

        // Table-driven push/pop/decode
        for (int i = 0; i < 10; i++) begin
            imm_sext = vecs[i].sext;
            push_word(vecs[i].instr);
            pop_word();
            check($sformatf("vec%0d opcode", i),   32'(opcodeOut),   32'(vecs[i].op));
            check($sformatf("vec%0d imm", i),      32'(immOut),      32'(vecs[i].imm));
            check($sformatf("vec%0d prefixed", i), 32'(ir_prefixed), 32'(vecs[i].pfx));
            check($sformatf("vec%0d ir_valid", i), 32'(ir_valid),    32'd1);
        end

        // Changing imm_sext re-extends the loaded IR combinationally
        imm_sext = 1'b1;
        push_word(16'hFFF3);
        pop_word();
        check("sext1 imm", 32'(immOut), 32'hFFFF);
        imm_sext = 1'b0;
        #1;
        check("sext0 imm", 32'(immOut), 32'h0FFF);

        // Fill to full; third word must be dropped
        push_word(16'h1111);
        push_word(16'h2222);
        check("full q_count",  32'(q_count),  32'd2);
        check("full in_ready", 32'(in_ready), 32'd0);
        push_word(16'h3333);
        check("drop q_count",  32'(q_count),  32'd2);
        pop_word();
        check("pop1 imm",      32'(immOut),   32'h0111);
        check("pop1 q_count",  32'(q_count),  32'd1);
        check("pop1 in_ready", 32'(in_ready), 32'd1);

        // Simultaneous push and pop at count=1
        in_valid = 1'b1;
        instr_in = 16'h4444;
        irw      = 1'b1;
        tick();
        in_valid = 1'b0;
        irw      = 1'b0;
        check("pushpop imm",     32'(immOut),  32'h0222);
        check("pushpop q_count", 32'(q_count), 32'd1);
        pop_word();
        check("after drop imm",  32'(immOut),  32'h0444);
        check("empty q_count",   32'(q_count), 32'd0);

        // irw on empty queue is a no-op
        pop_word();
        check("empty irw imm",      32'(immOut),    32'h0444);
        check("empty irw opcode",   32'(opcodeOut), 32'h4);
        check("empty irw ir_valid", 32'(ir_valid),  32'd1);
        check("empty irw q_count",  32'(q_count),   32'd0);

        // No bypass: push and irw together on an empty queue do not load IR
        in_valid = 1'b1;
        instr_in = 16'h0567;
        irw      = 1'b1;
        tick();
        in_valid = 1'b0;
        irw      = 1'b0;
        check("nobypass imm",     32'(immOut),  32'h0444);
        check("nobypass q_count", 32'(q_count), 32'd1);
        pop_word();
        check("nobypass pop imm", 32'(immOut),  32'h0056);

        // Comp code write and hold
        cc_in = 2'b10;
        ccw   = 1'b1;
        tick();
        check("cc write", 32'(compcodeOut), 32'h2);
        cc_in = 2'b01;
        ccw   = 1'b0;
        tick();
        check("cc hold",  32'(compcodeOut), 32'h2);

        // Reset while a prefix is pending with one queued entry
        push_word(16'h005E);
        pop_word();
        push_word(16'h1111);
        check("pre-rst q_count", 32'(q_count), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        instr_in = 16'h2222;
        irw      = 1'b1;
        ccw      = 1'b1;
        cc_in    = 2'b11;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        irw      = 1'b0;
        ccw      = 1'b0;
        check("midrst q_count",  32'(q_count),     32'd0);
        check("midrst ir_valid", 32'(ir_valid),    32'd0);
        check("midrst compcode", 32'(compcodeOut), 32'd0);
        check("midrst imm",      32'(immOut),      32'd0);
        check("midrst in_ready", 32'(in_ready),    32'd1);
        push_word(16'h0121);
        pop_word();
        check("post-rst prefixed", 32'(ir_prefixed), 32'd0);
        check("post-rst imm",      32'(immOut),      32'h0012);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
